// File: rtl/ldm_stm_sequencer.sv
// Decode-stage sequencer that expands ARM LDM/STM block transfers into single-register
// LDR/STR immediate micro-ops plus an optional base-writeback ADD/SUB.
module ldm_stm_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic        StallD,
    input  logic        FlushD,
    output logic [31:0] UopInstrD,
    output logic        StallFuop,
    output logic        UopBusyD,
    output logic        UopLastD,
    output logic        LDMSTMforwardD,
    output logic        doNotUpdateFlagD
);
    typedef enum logic [1:0] {IDLE, SEQ, WB, PCLD} seqState_t;

    localparam logic [31:0] NopInstr = 32'hE1A00000;

    seqState_t   state, nextState;
    logic [15:0] remMaskQ, listQ;
    logic [3:0]  condQ, rnQ;
    logic        pQ, uQ, lQ, wbEnQ;

    function automatic logic [4:0] popCount(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'b0000, v[i]};
        return c;
    endfunction

    function automatic logic [3:0] lowestSet(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

    logic        isBusy, emitReg, emitWb, emitPc, more;
    logic [3:0]  cond, rn, rd, rdSel;
    logic        p, u, l, wbEn;
    logic [15:0] list, remMask, regFilter, regMask, lowMask, nextMask;
    logic [4:0]  n;
    logic [7:0]  n4;
    logic [8:0]  rank4, off, absOff;

    // In IDLE the first micro-op is decoded straight from InstrD; afterwards from latched fields.
    always_comb begin
        if (state == IDLE) begin
            cond    = InstrD[31:28];
            p       = InstrD[24];
            u       = InstrD[23];
            l       = InstrD[20];
            rn      = InstrD[19:16];
            list    = InstrD[15:0];
            remMask = InstrD[15:0];
            wbEn    = InstrD[21] & ~(InstrD[20] & list[rn]);
            isBusy  = (InstrD[27:25] == 3'b100);
        end else begin
            cond    = condQ;
            p       = pQ;
            u       = uQ;
            l       = lQ;
            rn      = rnQ;
            list    = listQ;
            remMask = remMaskQ;
            wbEn    = wbEnQ;
            isBusy  = 1'b1;
        end
    end

    always_comb begin
        n         = popCount(list);
        n4        = {1'b0, n, 2'b00};
        // Loads hold back Rn and r15; Rn goes last among registers, r15 after writeback.
        regFilter = l ? 16'h7FFF : 16'hFFFF;
        regMask   = remMask & regFilter;
        lowMask   = l ? (regMask & ~(16'h1 << rn)) : regMask;
        rdSel     = (lowMask != '0) ? lowestSet(lowMask) : rn;
        emitReg   = (state == IDLE || state == SEQ) && (regMask != '0);
        emitWb    = (state == WB) || (state == IDLE && regMask == '0 && list != '0 && wbEn);
        emitPc    = (state == PCLD) || (state == IDLE && regMask == '0 && list != '0 && !wbEn);
        rd        = emitPc ? 4'd15 : rdSel;
        nextMask  = emitReg ? (remMask & ~(16'h1 << rdSel)) : remMask;

        nextState = IDLE;
        more      = 1'b0;
        if (emitReg && (nextMask & regFilter) != '0) begin
            nextState = SEQ;
            more      = 1'b1;
        end else if (emitReg && wbEn) begin
            nextState = WB;
            more      = 1'b1;
        end else if (!emitPc && l && nextMask[15]) begin
            nextState = PCLD;
            more      = 1'b1;
        end

        rank4 = {2'b00, popCount(list & ((16'h1 << rd) - 16'h1)), 2'b00};
        case ({p, u})
            2'b01:   off = rank4;
            2'b11:   off = rank4 + 9'd4;
            2'b00:   off = rank4 - {1'b0, n4} + 9'd4;
            default: off = rank4 - {1'b0, n4};
        endcase
        // A PC load issued after writeback addresses relative to the already-updated base.
        if (emitPc && wbEn) off = u ? (off - {1'b0, n4}) : (off + {1'b0, n4});
        absOff = off[8] ? (9'd0 - off) : off;
    end

    always_comb begin
        UopBusyD         = isBusy;
        UopLastD         = isBusy & ~more;
        StallFuop        = isBusy & more;
        LDMSTMforwardD   = isBusy;
        doNotUpdateFlagD = isBusy;
        if (!isBusy)
            UopInstrD = InstrD;
        else if (list == '0)
            UopInstrD = NopInstr;
        else if (emitWb)
            UopInstrD = {cond, 3'b001, u ? 4'b0100 : 4'b0010, 1'b0, rn, rn, 4'b0000, n4};
        else
            UopInstrD = {cond, 3'b010, 1'b1, ~off[8], 1'b0, 1'b0, l, rn, rd, 3'b000, absOff};
    end

    // NOTE: only state and the remaining mask are reset; the latched fields are read
    // only outside IDLE and are always rewritten on the IDLE exit edge.
    always_ff @(posedge clk) begin
        if (!reset || FlushD) begin
            state    <= IDLE;
            remMaskQ <= '0;
        end else if (!StallD && isBusy) begin
            if (more) begin
                state    <= nextState;
                remMaskQ <= nextMask;
                if (state == IDLE) begin
                    condQ <= cond;
                    pQ    <= p;
                    uQ    <= u;
                    lQ    <= l;
                    rnQ   <= rn;
                    listQ <= list;
                    wbEnQ <= wbEn;
                end
            end else begin
                state    <= IDLE;
                remMaskQ <= '0;
            end
        end
    end
endmodule
